// File: rtl/dp_pkg.sv
// Shared types and constants for the micro-op sequencer datapath.
//   state_t : sequencer FSM states
//   uop_t   : 24-bit micro-op word layout
//   ALU_*   : opcode constants used by micro-programs
package dp_pkg;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned NREG   = 16;
  localparam int unsigned WORD_W = 24;
  localparam int unsigned OP_W   = 8;
  localparam int unsigned SEL_W  = 4;

  // Micro-op field offsets
  localparam int unsigned LAST_B   = 21;
  localparam int unsigned WEN_B    = 20;
  localparam int unsigned DEST_MSB = 19;
  localparam int unsigned DEST_LSB = 16;
  localparam int unsigned SRCA_MSB = 15;
  localparam int unsigned SRCA_LSB = 12;
  localparam int unsigned SRCB_MSB = 11;
  localparam int unsigned SRCB_LSB = 8;
  localparam int unsigned OP_MSB   = 7;
  localparam int unsigned OP_LSB   = 0;

  // ALU opcodes
  localparam logic [OP_W-1:0] ALU_NOP = 8'h00;
  localparam logic [OP_W-1:0] ALU_ADD = 8'h11;
  localparam logic [OP_W-1:0] ALU_SUB = 8'h12;
  localparam logic [OP_W-1:0] ALU_AND = 8'h21;
  localparam logic [OP_W-1:0] ALU_OR  = 8'h22;
  localparam logic [OP_W-1:0] ALU_XOR = 8'h23;
  localparam logic [OP_W-1:0] ALU_MOV = 8'h30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [1:0]       rsvd;
    logic             last;
    logic             wen;
    logic [SEL_W-1:0] dest;
    logic [SEL_W-1:0] srca;
    logic [SEL_W-1:0] srcb;
    logic [OP_W-1:0]  aluop;
  } uop_t;

  // Split a raw RAM word into micro-op fields
  function automatic uop_t uop_decode(input logic [WORD_W-1:0] w);
    uop_t u;
    u.rsvd  = w[WORD_W-1:LAST_B+1];
    u.last  = w[LAST_B];
    u.wen   = w[WEN_B];
    u.dest  = w[DEST_MSB:DEST_LSB];
    u.srca  = w[SRCA_MSB:SRCA_LSB];
    u.srcb  = w[SRCB_MSB:SRCB_LSB];
    u.aluop = w[OP_MSB:OP_LSB];
    return u;
  endfunction

endpackage

// File: rtl/useq_ram.sv
// Micro-op program store: simple dual-port RAM, one synchronous write port
// and one synchronous (registered) read port. Contents are not reset.
//   clock        : clock
//   we/waddr/wdata : write port
//   re/raddr     : read request; rdata updates on the edge where re is high
//   rdata        : registered read data (acts as the instruction register)
module useq_ram #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 24
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write and registered read
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/datapath_microseq.sv
// Programmable micro-op sequencer. The host loads a program into the RAM
// while idle and pulses start; each micro-op takes a FETCH and an EXEC
// cycle, and EXEC drives the regfile write enable, ALU opcode and read
// selects. done pulses once after the last op.
//   clock, Reset          : clock, synchronous active-high reset
//   prog_we/addr/data     : program load (IDLE only)
//   start, halt           : run from address 0 / abort run
//   reg_wen, alu_op,
//   rega_sel, regb_sel    : datapath controls, nonzero only in EXEC
//   pc                    : current micro-op address
//   busy, done            : running status, completion pulse
import dp_pkg::*;

module datapath_microseq (
  input  logic              clock,
  input  logic              Reset,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [WORD_W-1:0] prog_data,
  input  logic              start,
  input  logic              halt,
  output logic [NREG-1:0]   reg_wen,
  output logic [OP_W-1:0]   alu_op,
  output logic [SEL_W-1:0]  rega_sel,
  output logic [SEL_W-1:0]  regb_sel,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done
);

  state_t            state;
  state_t            state_nxt;
  logic [WORD_W-1:0] ir_word;
  uop_t              ir;
  logic [1:0]        ir_rsvd_unused;
  logic              last_op;

  // Program RAM; its read register is the instruction register
  useq_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (WORD_W)
  ) u_ram (
    .clock (clock),
    .we    (prog_we && (state == IDLE)),
    .waddr (prog_addr),
    .wdata (prog_data),
    .re    (state == FETCH),
    .raddr (pc),
    .rdata (ir_word)
  );

  assign ir             = uop_decode(ir_word);
  assign ir_rsvd_unused = ir.rsvd;

  // Terminate on the last flag or at the top of RAM (no wrap-around)
  assign last_op = ir.last || (pc == ADDR_W'(DEPTH - 1));

  // State register
  always_ff @(posedge clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Program counter
  always_ff @(posedge clock) begin
    if (Reset) begin
      pc <= '0;
    end else begin
      case (state)
        IDLE:    if (start) pc <= '0;
        FETCH:   if (halt)  pc <= '0;
        EXEC: begin
          if (halt)          pc <= '0;
          else if (!last_op) pc <= pc + ADDR_W'(1);
        end
        default: pc <= pc;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = FETCH;
      FETCH: state_nxt = halt ? IDLE : EXEC;
      EXEC: begin
        if (halt)         state_nxt = IDLE;
        else if (last_op) state_nxt = DONE;
        else              state_nxt = FETCH;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from registered state and instruction register
  always_comb begin
    reg_wen  = '0;
    alu_op   = ALU_NOP;
    rega_sel = '0;
    regb_sel = '0;
    busy     = (state == FETCH) || (state == EXEC);
    done     = (state == DONE);
    if (state == EXEC) begin
      alu_op   = ir.aluop;
      rega_sel = ir.srca;
      regb_sel = ir.srcb;
      // A halted op must not commit its register write
      if (ir.wen && !halt) reg_wen = NREG'(1) << ir.dest;
    end
  end

endmodule

// File: tb/tb_datapath_microseq.sv
// Directed self-checking bench for datapath_microseq.
import dp_pkg::*;

module tb_datapath_microseq;

  logic              clock = 1'b0;
  logic              Reset;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [WORD_W-1:0] prog_data;
  logic              start;
  logic              halt;
  logic [NREG-1:0]   reg_wen;
  logic [OP_W-1:0]   alu_op;
  logic [SEL_W-1:0]  rega_sel;
  logic [SEL_W-1:0]  regb_sel;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              done;

  int errors = 0;
  int checks = 0;

  datapath_microseq dut (
    .clock     (clock),
    .Reset     (Reset),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .start     (start),
    .halt      (halt),
    .reg_wen   (reg_wen),
    .alu_op    (alu_op),
    .rega_sel  (rega_sel),
    .regb_sel  (regb_sel),
    .pc        (pc),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [WORD_W-1:0] mk(input logic last, input logic wen,
                                           input logic [3:0] dest, input logic [3:0] srca,
                                           input logic [3:0] srcb, input logic [7:0] op);
    return {2'b00, last, wen, dest, srca, srcb, op};
  endfunction

  task automatic load(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] w);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = w;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic exec_chk(input string tag, input logic [15:0] wen, input logic [7:0] op,
                          input logic [3:0] sa, input logic [3:0] sb, input logic [3:0] p);
    check({tag, ".reg_wen"}, 32'(reg_wen), 32'(wen));
    check({tag, ".alu_op"},  32'(alu_op),  32'(op));
    check({tag, ".rega"},    32'(rega_sel), 32'(sa));
    check({tag, ".regb"},    32'(regb_sel), 32'(sb));
    check({tag, ".pc"},      32'(pc),       32'(p));
    check({tag, ".busy"},    32'(busy),     32'd1);
  endtask

  initial begin
    Reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    start = 1'b0; halt = 1'b0;
    tick(); tick();
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.pc", 32'(pc), 32'd0);
    check("rst.reg_wen", 32'(reg_wen), 32'd0);
    check("rst.alu_op", 32'(alu_op), 32'd0);
    Reset = 1'b0;
    tick();

    // 1: reset while executing op 1
    load(4'd0, mk(1'b0, 1'b1, 4'd5, 4'd3, 4'd4, ALU_SUB));
    load(4'd1, mk(1'b0, 1'b1, 4'd6, 4'd7, 4'd8, ALU_AND));
    start = 1'b1; tick(); start = 1'b0;         // FETCH 0
    tick();                                      // EXEC 0
    exec_chk("t1.e0", 16'h0020, ALU_SUB, 4'd3, 4'd4, 4'd0);
    tick(); tick();                              // FETCH 1, EXEC 1
    exec_chk("t1.e1", 16'h0040, ALU_AND, 4'd7, 4'd8, 4'd1);
    Reset = 1'b1; tick(); Reset = 1'b0;
    check("t1.busy", 32'(busy), 32'd0);
    check("t1.reg_wen", 32'(reg_wen), 32'd0);
    check("t1.pc", 32'(pc), 32'd0);
    check("t1.alu_op", 32'(alu_op), 32'd0);

    // 2: single op, written in the same cycle as start
    prog_we = 1'b1; prog_addr = 4'd0;
    prog_data = mk(1'b1, 1'b1, 4'd2, 4'd1, 4'd0, ALU_ADD);
    start = 1'b1;
    tick();                                      // FETCH
    prog_we = 1'b0; start = 1'b0;
    check("t2.fetch.busy", 32'(busy), 32'd1);
    check("t2.fetch.reg_wen", 32'(reg_wen), 32'd0);
    check("t2.fetch.alu_op", 32'(alu_op), 32'd0);
    tick();                                      // EXEC
    exec_chk("t2.e0", 16'h0004, 8'h11, 4'd1, 4'd0, 4'd0);
    check("t2.e0.done", 32'(done), 32'd0);
    tick();                                      // DONE
    check("t2.done", 32'(done), 32'd1);
    check("t2.done.busy", 32'(busy), 32'd0);
    check("t2.done.reg_wen", 32'(reg_wen), 32'd0);
    tick();                                      // IDLE
    check("t2.idle.done", 32'(done), 32'd0);

    // 3: three ops, middle one has no write
    load(4'd0, mk(1'b0, 1'b1, 4'd3,  4'd4, 4'd5, ALU_OR));
    load(4'd1, mk(1'b0, 1'b0, 4'd7,  4'd6, 4'd7, ALU_MOV));
    load(4'd2, mk(1'b1, 1'b1, 4'd15, 4'd8, 4'd9, ALU_XOR));
    start = 1'b1; tick(); start = 1'b0;
    check("t3.f0.reg_wen", 32'(reg_wen), 32'd0);
    tick(); exec_chk("t3.e0", 16'h0008, 8'h22, 4'd4, 4'd5, 4'd0);
    tick(); check("t3.f1.reg_wen", 32'(reg_wen), 32'd0);
    check("t3.f1.done", 32'(done), 32'd0);
    tick(); exec_chk("t3.e1", 16'h0000, 8'h30, 4'd6, 4'd7, 4'd1);
    tick(); check("t3.f2.pc", 32'(pc), 32'd2);
    tick(); exec_chk("t3.e2", 16'h8000, 8'h23, 4'd8, 4'd9, 4'd2);
    tick(); check("t3.done", 32'(done), 32'd1);
    check("t3.done.pc", 32'(pc), 32'd2);
    tick(); check("t3.idle.done", 32'(done), 32'd0);
    check("t3.idle.pc", 32'(pc), 32'd2);

    // 4: full RAM without last flag stops at the top
    for (int i = 0; i < 16; i++)
      load(4'(i), mk(1'b0, 1'b1, 4'(i), 4'(i), 4'(15 - i), 8'(8'h80 + i)));
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("t4.reg_wen", 32'(reg_wen), 32'(16'(1) << i));
      check("t4.alu_op", 32'(alu_op), 32'(8'h80 + i));
      check("t4.pc", 32'(pc), 32'(i));
      tick();
      if (i < 15) check("t4.fetch.done", 32'(done), 32'd0);
    end
    check("t4.done", 32'(done), 32'd1);
    check("t4.done.pc", 32'(pc), 32'd15);
    tick();
    check("t4.idle.pc", 32'(pc), 32'd15);
    check("t4.idle.busy", 32'(busy), 32'd0);
    check("t4.idle.done", 32'(done), 32'd0);

    // 5: halt on the EXEC of op 1; also 6: prog_we while busy is ignored
    start = 1'b1; tick(); start = 1'b0;          // FETCH 0
    prog_we = 1'b1; prog_addr = 4'd0;
    prog_data = mk(1'b1, 1'b1, 4'd9, 4'd9, 4'd9, 8'h5a);
    tick();                                      // EXEC 0
    tick();                                      // FETCH 1
    tick();                                      // EXEC 1
    halt = 1'b1; #1;
    check("t5.halt.reg_wen", 32'(reg_wen), 32'd0);
    check("t5.halt.alu_op", 32'(alu_op), 32'h81);
    check("t5.halt.rega", 32'(rega_sel), 32'd1);
    tick();
    halt = 1'b0; prog_we = 1'b0;
    check("t5.busy", 32'(busy), 32'd0);
    check("t5.pc", 32'(pc), 32'd0);
    check("t5.done", 32'(done), 32'd0);
    tick();
    check("t5.done2", 32'(done), 32'd0);
    check("t5.busy2", 32'(busy), 32'd0);

    start = 1'b1; tick(); start = 1'b0;
    tick();
    exec_chk("t6.e0", 16'h0001, 8'h80, 4'd0, 4'd15, 4'd0);
    halt = 1'b1; tick(); halt = 1'b0;
    check("t6.busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
